// File: rtl/button_pkg.sv
// Shared constants and types for the pushbutton conditioner.
package button_pkg;

    // Default timing at a 50 MHz system clock.
    localparam int DEBOUNCE_10MS_50MHZ = 500_000;
    localparam int REPEAT_DELAY_500MS  = 25_000_000;
    localparam int REPEAT_RATE_100MS   = 5_000_000;

    // Pin polarity selectors.
    localparam bit POL_ACTIVE_LOW  = 1'b1;
    localparam bit POL_ACTIVE_HIGH = 1'b0;

    // Per-button auto-repeat state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Larger of two integers, used to size the shared repeat counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton: polarity fix, 2-flop synchronizer, debounce, edge
// pulses and optional hold-to-repeat.
module button_channel
    import button_pkg::*;
#(
    parameter bit ACTIVE_LOW      = POL_ACTIVE_LOW,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_RATE     = REPEAT_RATE_100MS
) (
    input  logic clk,
    input  logic reset,
    input  logic repeat_en_i,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o,
    output logic btn_repeating_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int RW   = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]   DLY_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]   RPT_LOAD = RW'(REPEAT_RATE - 1);

    logic            raw_act;
    logic            sync1_q, sync2_q;
    logic            level_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            accept, rise, fall;

    rpt_state_e      state_q;
    logic [RW-1:0]   rpt_cnt_q;
    logic            press_q, release_q, repeating_q;

    // Normalise so that 1 always means pressed; reset value 0 is "released".
    assign raw_act = ACTIVE_LOW ? ~btn_raw_i : btn_raw_i;

    // Two-stage synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_act;
            sync2_q <= sync1_q;
        end
    end

    // The new level is accepted on the edge where the counter has already
    // seen DEBOUNCE_CYCLES-1 mismatching cycles and the mismatch persists.
    assign accept = (sync2_q != level_q) && (db_cnt_q == DB_LAST);
    assign rise   = accept && !level_q;
    assign fall   = accept &&  level_q;

    // Debounce: count consecutive mismatching cycles, any match restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else if (sync2_q == level_q) begin
            db_cnt_q <= '0;
        end else if (accept) begin
            level_q  <= ~level_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    // Edge pulses and repeat FSM. A falling level always wins over a repeat
    // tick landing on the same cycle, so no pulse follows the release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rpt_cnt_q   <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            press_q   <= rise;
            release_q <= fall;
            case (state_q)
                IDLE: begin
                    repeating_q <= 1'b0;
                    if (rise && repeat_en_i) begin
                        state_q   <= DELAY;
                        rpt_cnt_q <= DLY_LOAD;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        state_q     <= IDLE;
                        repeating_q <= 1'b0;
                    end else if (rpt_cnt_q == '0) begin
                        state_q     <= REPEAT;
                        press_q     <= 1'b1;
                        repeating_q <= 1'b1;
                        rpt_cnt_q   <= RPT_LOAD;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q - 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state_q     <= IDLE;
                        repeating_q <= 1'b0;
                    end else if (rpt_cnt_q == '0) begin
                        press_q   <= 1'b1;
                        rpt_cnt_q <= RPT_LOAD;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    repeating_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level_o     = level_q;
    assign btn_press_o     = press_q;
    assign btn_release_o   = release_q;
    assign btn_repeating_o = repeating_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw timer pushbuttons into clean level, press, release
// and auto-repeat events; one independent channel per button.
module button_conditioner
    import button_pkg::*;
#(
    parameter int                 NUM_BTN         = 3,
    parameter bit                 ACTIVE_LOW      = POL_ACTIVE_LOW,
    parameter int                 DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int                 REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int                 REPEAT_RATE     = REPEAT_RATE_100MS,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(3'b010)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeating
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk             (clk),
            .reset           (reset),
            .repeat_en_i     (REPEAT_MASK[i]),
            .btn_raw_i       (btn_raw[i]),
            .btn_level_o     (btn_level[i]),
            .btn_press_o     (btn_press[i]),
            .btn_release_o   (btn_release[i]),
            .btn_repeating_o (btn_repeating[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected output
// events (cycle + full output snapshot); a monitor pops and compares each
// time any output pulses or changes level.
module tb_button_conditioner;

    localparam int NB = 3;
    localparam int LAT = 6;   // DEBOUNCE_CYCLES + 2

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeating;

    button_conditioner #(
        .NUM_BTN         (NB),
        .ACTIVE_LOW      (1'b0),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .REPEAT_MASK     (3'b010)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .btn_repeating (btn_repeating)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] rep;
        logic [NB-1:0] lvl;
    } ev_t;

    ev_t q[$];
    int  n_pass = 0;
    int  n_total = 0;

    task automatic expect_ev(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r,
                             input logic [NB-1:0] rp, input logic [NB-1:0] l);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.rep = rp; e.lvl = l;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [NB-1:0] v, output int c);
        @(negedge clk);
        btn_raw = v;
        c = cyc;
    endtask

    // Button 1 (masked) raised at cycle c0 and dropped at c0+hold: press,
    // repeat pulses before the accepted release, then the release.
    task automatic hold_masked(input int c0, input int hold);
        int t, rel;
        t   = c0 + LAT;
        rel = c0 + hold + LAT;
        expect_ev(t, 3'b010, 3'b000, 3'b000, 3'b010);
        for (int k = t + 10; k < rel; k += 3)
            expect_ev(k, 3'b010, 3'b000, 3'b010, 3'b010);
        expect_ev(rel, 3'b000, 3'b010, 3'b000, 3'b000);
    endtask

    // Monitor: sole owner of the pass/total counters.
    initial begin
        ev_t           e;
        logic [NB-1:0] prev_rep = '0, prev_lvl = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_total++;
                if ({btn_level, btn_press, btn_release, btn_repeating} == '0) n_pass++;
                else $display("FAIL reset_outputs @%0d: got lvl=%b prs=%b rel=%b rep=%b, want all 0",
                              cyc, btn_level, btn_press, btn_release, btn_repeating);
                prev_rep = '0;
                prev_lvl = '0;
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    n_total++;
                    $display("FAIL missing_event: expected at cycle %0d prs=%b rel=%b rep=%b lvl=%b, not observed",
                             e.cyc, e.press, e.rel, e.rep, e.lvl);
                end
                if (btn_press != '0 || btn_release != '0 ||
                    btn_repeating != prev_rep || btn_level != prev_lvl) begin
                    n_total++;
                    if (q.size() == 0) begin
                        $display("FAIL unexpected_event @%0d: got prs=%b rel=%b rep=%b lvl=%b, want no activity",
                                 cyc, btn_press, btn_release, btn_repeating, btn_level);
                    end else begin
                        e = q[0];
                        if (e.cyc == cyc && e.press == btn_press && e.rel == btn_release &&
                            e.rep == btn_repeating && e.lvl == btn_level) begin
                            n_pass++;
                            void'(q.pop_front());
                        end else begin
                            $display("FAIL event @%0d: got prs=%b rel=%b rep=%b lvl=%b, want @%0d prs=%b rel=%b rep=%b lvl=%b",
                                     cyc, btn_press, btn_release, btn_repeating, btn_level,
                                     e.cyc, e.press, e.rel, e.rep, e.lvl);
                            if (e.cyc == cyc) void'(q.pop_front());
                        end
                    end
                end
                prev_rep = btn_repeating;
                prev_lvl = btn_level;
            end
        end
    end

    initial begin
        int c0, c1, cr;

        // Reset state held for a few cycles.
        idle(3);
        @(negedge clk);
        reset = 1'b0;
        idle(3);

        // 1: clean press/release on unmasked button 0.
        drive(3'b001, c0);
        expect_ev(c0 + LAT, 3'b001, 3'b000, 3'b000, 3'b001);
        idle(19);
        drive(3'b000, c1);
        expect_ev(c1 + LAT, 3'b000, 3'b001, 3'b000, 3'b000);
        idle(12);

        // 2: bounce on button 2, each level only 3 cycles: no activity.
        drive(3'b100, c0);
        idle(2);
        drive(3'b000, c0);
        idle(2);
        drive(3'b100, c0);
        idle(2);
        drive(3'b000, c0);
        idle(15);

        // 3: auto-repeat on button 1, held 30 cycles.
        drive(3'b010, c0);
        hold_masked(c0, 30);
        idle(29);
        drive(3'b000, c1);
        idle(15);

        // 4: release accepted at t+8, still in DELAY.
        drive(3'b010, c0);
        hold_masked(c0, 8);
        idle(7);
        drive(3'b000, c1);
        idle(15);

        // 5: all three buttons together.
        drive(3'b111, c0);
        expect_ev(c0 + LAT,     3'b111, 3'b000, 3'b000, 3'b111);
        expect_ev(c0 + 8 + LAT, 3'b000, 3'b111, 3'b000, 3'b000);
        idle(7);
        drive(3'b000, c1);
        idle(15);

        // 6: reset mid-repeat with button 1 held through reset release.
        drive(3'b010, c0);
        expect_ev(c0 + LAT,      3'b010, 3'b000, 3'b000, 3'b010);
        expect_ev(c0 + LAT + 10, 3'b010, 3'b000, 3'b010, 3'b010);
        expect_ev(c0 + LAT + 13, 3'b010, 3'b000, 3'b010, 3'b010);
        idle(20);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(3);
        reset = 1'b0;
        cr = cyc;
        hold_masked(cr, 20);
        idle(19);
        drive(3'b000, c1);
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
